// File: rtl/u_stream_pkg.sv
// rtl/u_stream_pkg.sv - shared types and helpers for the multi-beat unary admission checker
package u_stream_pkg;

    typedef struct packed {
        logic all_ones;
        logic all_zeros_n;
        logic seen_edge;
        logic x_prev;
        logic is_unary;
        logic is_unary_n;
    } carry_t;

    typedef enum logic {
        ACC  = 1'b0,
        RESP = 1'b1
    } state_e;

    function automatic int count_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/u_stream_cell.sv
// rtl/u_stream_cell.sv - one-bit unary detection cell; folds bit x into the running carry state
module c_cell
    import u_stream_pkg::*;
#(
    parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1
) (
    input  logic   x,
    input  logic   is_first,
    input  carry_t cin,
    output carry_t cout
);

    logic flip;

    always_comb begin
        cout = cin;
        flip = 1'b0;
        if (is_first) begin
            // The first bit picks which of the two codes is still possible.
            cout.all_ones    = x;
            cout.all_zeros_n = ~x;
            cout.seen_edge   = 1'b0;
            cout.x_prev      = x;
            cout.is_unary    = x;
            cout.is_unary_n  = ~x & P_ADMIT_COMPLIMENT_EN;
        end else begin
            flip             = x ^ cin.x_prev;
            cout.all_ones    = cin.all_ones & x;
            cout.all_zeros_n = cin.all_zeros_n & ~x;
            cout.seen_edge   = cin.seen_edge | flip;
            cout.x_prev      = x;
            cout.is_unary    = cin.is_unary & ~(flip & cin.seen_edge);
            cout.is_unary_n  = cin.is_unary_n & ~(flip & cin.seen_edge);
        end
    end

endmodule

// File: rtl/u_stream_chunk.sv
// rtl/u_stream_chunk.sv - C-bit combinational cell chain plus beat popcount (pop only with U_STREAM_CHECK_COUNT_EN)
module u_stream_chunk
    import u_stream_pkg::*;
#(
    parameter int C                     = 16,
    parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1
) (
    input  logic [C-1:0]            dat,
    input  logic                    is_first,
    input  carry_t                  cin,
    output carry_t                  cout
`ifdef U_STREAM_CHECK_COUNT_EN
    ,
    output logic [$clog2(C+1)-1:0]  pop
`endif
);

    carry_t chain [C+1];

    assign chain[0] = cin;

    for (genvar j = 0; j < C; j++) begin : g_cell
        c_cell #(
            .P_ADMIT_COMPLIMENT_EN(P_ADMIT_COMPLIMENT_EN)
        ) u_cell (
            .x        (dat[j]),
            .is_first ((j == 0) ? is_first : 1'b0),
            .cin      (chain[j]),
            .cout     (chain[j+1])
        );
    end

    assign cout = chain[C];

`ifdef U_STREAM_CHECK_COUNT_EN
    localparam int PW = $clog2(C + 1);

    always_comb begin
        pop = '0;
        for (int j = 0; j < C; j++) begin
            pop = pop + PW'(dat[j]);
        end
    end
`endif

endmodule

// File: rtl/u_stream_check.sv
// rtl/u_stream_check.sv - streamed W-bit unary/complemented-unary checker; run-length counting under U_STREAM_CHECK_COUNT_EN
module u_stream_check
    import u_stream_pkg::*;
#(
    parameter int W                     = 64,
    parameter int C                     = 16,
    parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_vld,
    output logic                                o_rdy,
    input  logic [C-1:0]                        i_dat,
    output logic                                o_vld,
    input  logic                                i_rdy,
    output logic                                o_is_unary,
    output logic                                o_is_unary_n,
    output logic [u_stream_pkg::count_w(W)-1:0] o_count
);

    localparam int NB = W / C;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = count_w(W);

    if ((W % C) != 0) begin : g_bad_width
        $error("u_stream_check: W must be a multiple of C");
    end

    state_e          state;
    logic [BW-1:0]   beat;
    carry_t          carry;
    carry_t          carry_nxt;
    logic            accept;
    logic            is_first;
    logic            last;
    logic [CW-1:0]   verdict_count;

    // In RESP the upstream sees ready only when the verdict drains this cycle.
    assign o_rdy    = (state == ACC) | i_rdy;
    assign accept   = i_vld & o_rdy;
    assign is_first = (beat == '0);
    assign last     = (beat == BW'(NB - 1));

`ifdef U_STREAM_CHECK_COUNT_EN
    localparam int PW = $clog2(C + 1);

    logic [PW-1:0] pop;
    logic [CW-1:0] ones;
    logic [CW-1:0] zeros;
    logic [CW-1:0] ones_nxt;
    logic [CW-1:0] zeros_nxt;
`endif

    u_stream_chunk #(
        .C                    (C),
        .P_ADMIT_COMPLIMENT_EN(P_ADMIT_COMPLIMENT_EN)
    ) u_chunk (
        .dat      (i_dat),
        .is_first (is_first),
        .cin      (carry),
        .cout     (carry_nxt)
`ifdef U_STREAM_CHECK_COUNT_EN
        ,
        .pop      (pop)
`endif
    );

`ifdef U_STREAM_CHECK_COUNT_EN
    always_comb begin
        ones_nxt  = (is_first ? '0 : ones) + CW'(pop);
        zeros_nxt = (is_first ? '0 : zeros) + (CW'(C) - CW'(pop));
        verdict_count = carry_nxt.is_unary   ? ones_nxt  :
                        carry_nxt.is_unary_n ? zeros_nxt : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ones  <= '0;
            zeros <= '0;
        end else if (accept) begin
            ones  <= ones_nxt;
            zeros <= zeros_nxt;
        end
    end
`else
    assign verdict_count = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ACC;
            beat         <= '0;
            carry        <= '0;
            o_vld        <= 1'b0;
            o_is_unary   <= 1'b0;
            o_is_unary_n <= 1'b0;
            o_count      <= '0;
        end else begin
            if (state == RESP && i_rdy) begin
                state <= ACC;
                o_vld <= 1'b0;
            end
            // A beat accepted while draining overrides the drain when it completes a vector.
            if (accept) begin
                carry <= carry_nxt;
                if (last) begin
                    beat         <= '0;
                    state        <= RESP;
                    o_vld        <= 1'b1;
                    o_is_unary   <= carry_nxt.is_unary;
                    o_is_unary_n <= carry_nxt.is_unary_n;
                    o_count      <= verdict_count;
                end else begin
                    beat <= beat + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_u_stream_check.sv
// tb/tb_u_stream_check.sv - self-checking bench for u_stream_check (W=16, C=4), admission enabled and disabled
module tb_u_stream_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_vld;
    logic [3:0] i_dat;
    logic       i_rdy;

    logic       rdy0, vld0, u0, un0;
    logic [4:0] cnt0;
    logic       rdy1, vld1, u1, un1;
    logic [4:0] cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    u_stream_check #(.W(16), .C(4), .P_ADMIT_COMPLIMENT_EN(1'b1)) dut_en (
        .i_clk(clk), .i_rst(rst), .i_vld(i_vld), .o_rdy(rdy0), .i_dat(i_dat),
        .o_vld(vld0), .i_rdy(i_rdy), .o_is_unary(u0), .o_is_unary_n(un0), .o_count(cnt0)
    );

    u_stream_check #(.W(16), .C(4), .P_ADMIT_COMPLIMENT_EN(1'b0)) dut_dis (
        .i_clk(clk), .i_rst(rst), .i_vld(i_vld), .o_rdy(rdy1), .i_dat(i_dat),
        .o_vld(vld1), .i_rdy(i_rdy), .o_is_unary(u1), .o_is_unary_n(un1), .o_count(cnt1)
    );

    typedef struct {
        logic [15:0] v;
        bit          u;
        bit          un;
        int          k;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cnt_exp(input int k);
`ifdef U_STREAM_CHECK_COUNT_EN
        return k;
`else
        return 0;
`endif
    endfunction

    // Reference: a unary code is 2^k-1 in the low bits (or its complement); k is the symbol's popcount.
    task automatic model(input logic [15:0] v, input bit en, output bit u, output bit un, output int k);
        int          ones;
        int          zeros;
        logic [16:0] m1;
        logic [16:0] m0;
        logic [15:0] nv;
        ones  = $countones(v);
        zeros = 16 - ones;
        nv    = ~v;
        m1    = (17'd1 << ones) - 17'd1;
        m0    = (17'd1 << zeros) - 17'd1;
        u     = v[0] && ({1'b0, v} == m1);
        un    = en && !v[0] && ({1'b0, nv} == m0);
        k     = u ? ones : (un ? zeros : 0);
    endtask

    // Entered and left just after a falling edge.
    task automatic send_beat(input logic [3:0] d);
        int n;
        i_vld = 1'b1;
        i_dat = d;
        #1;
        n = 0;
        while (!rdy0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rdy0) chk("beat_ready_timeout", rdy0, 1);
        @(posedge clk);
        @(negedge clk);
        i_vld = 1'b0;
        i_dat = 4'($urandom);
    endtask

    task automatic send_vec(input logic [15:0] v, input int maxgap);
        for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, maxgap)) begin
                i_vld = 1'b0;
                i_dat = 4'($urandom);
                @(negedge clk);
            end
            send_beat(v[b*4 +: 4]);
        end
    endtask

    task automatic check_now(input string nm, input bit eu, input bit eun, input int ek);
        #1;
        chk({nm, ".vld"}, vld0, 1);
        chk({nm, ".u"}, u0, eu);
        chk({nm, ".un"}, un0, eun);
        chk({nm, ".cnt"}, cnt0, cnt_exp(ek));
        chk({nm, ".dis_vld"}, vld1, 1);
        chk({nm, ".dis_u"}, u1, eu);
        chk({nm, ".dis_un"}, un1, 0);
        chk({nm, ".dis_cnt"}, cnt1, eu ? cnt_exp(ek) : 0);
    endtask

    task automatic stall(input string nm, input int cycles, input bit eu, input int ek);
        repeat (cycles) begin
            i_rdy = 1'b0;
            @(negedge clk);
            #1;
            chk({nm, ".stall_rdy"}, rdy0, 0);
            chk({nm, ".stall_vld"}, vld0, 1);
            chk({nm, ".stall_u"}, u0, eu);
            chk({nm, ".stall_cnt"}, cnt0, cnt_exp(ek));
        end
    endtask

    task automatic consume(input string nm);
        i_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rdy = 1'b0;
        #1;
        chk({nm, ".drained"}, vld0, 0);
    endtask

    vec_t plan [11];

    initial begin
        bit          eu, eun, du, dun;
        int          ek, dk;
        logic [15:0] v;

        plan[0]  = '{16'h00FF, 1'b1, 1'b0, 8};
        plan[1]  = '{16'h000F, 1'b1, 1'b0, 4};
        plan[2]  = '{16'hFFFF, 1'b1, 1'b0, 16};
        plan[3]  = '{16'h0000, 1'b0, 1'b1, 16};
        plan[4]  = '{16'hFF00, 1'b0, 1'b1, 8};
        plan[5]  = '{16'h0F0F, 1'b0, 1'b0, 0};
        plan[6]  = '{16'h0001, 1'b1, 1'b0, 1};
        plan[7]  = '{16'hFFFE, 1'b0, 1'b1, 1};
        plan[8]  = '{16'h7FFF, 1'b1, 1'b0, 15};
        plan[9]  = '{16'h8000, 1'b0, 1'b1, 15};
        plan[10] = '{16'h0002, 1'b0, 1'b0, 0};

        rst   = 1'b1;
        i_vld = 1'b0;
        i_dat = 4'h0;
        i_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.vld", vld0, 0);
        chk("reset.u", u0, 0);
        chk("reset.un", un0, 0);
        chk("reset.cnt", cnt0, 0);
        chk("reset.rdy", rdy0, 1);

        for (int i = 0; i < 11; i++) begin
            send_vec(plan[i].v, 0);
            check_now($sformatf("plan%0d", i), plan[i].u, plan[i].un, plan[i].k);
            consume($sformatf("plan%0d", i));
        end

        // Backpressure, then the next vector's beat 0 rides in on the drain cycle.
        send_vec(16'h00FF, 1);
        check_now("bp", 1'b1, 1'b0, 8);
        stall("bp", 5, 1'b1, 8);
        i_rdy = 1'b1;
        i_vld = 1'b1;
        i_dat = 4'h1;
        @(posedge clk);
        @(negedge clk);
        i_rdy = 1'b0;
        i_vld = 1'b0;
        #1;
        chk("overlap.drained", vld0, 0);
        send_beat(4'h0);
        send_beat(4'h0);
        #1;
        chk("overlap.no_early_vld", vld0, 0);
        send_beat(4'h0);
        check_now("overlap", 1'b1, 1'b0, 1);
        consume("overlap");

        // Reset mid-vector after three beats of 0F0F.
        send_beat(4'hF);
        send_beat(4'h0);
        send_beat(4'hF);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst.vld", vld0, 0);
        send_vec(16'h00FF, 0);
        check_now("midrst", 1'b1, 1'b0, 8);
        consume("midrst");
        repeat (3) @(negedge clk);
        #1;
        chk("midrst.single_verdict", vld0, 0);

        // Reset while a verdict is pending drops it.
        send_vec(16'hFF00, 0);
        check_now("resprst", 1'b0, 1'b1, 8);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("resprst.vld", vld0, 0);
        chk("resprst.rdy", rdy0, 1);
        chk("resprst.un", un0, 0);

        for (int n = 0; n < 200; n++) begin
            int sel;
            int k;
            sel = $urandom_range(0, 3);
            k   = $urandom_range(1, 16);
            v   = 16'((17'd1 << k) - 17'd1);
            case (sel)
                0: ;
                1: v = ~v;
                2: v = 16'($urandom);
                default: v = v ^ (16'h1 << $urandom_range(1, 15));
            endcase
            model(v, 1'b1, eu, eun, ek);
            model(v, 1'b0, du, dun, dk);
            send_vec(v, 2);
            #1;
            chk($sformatf("rnd%0d.vld", n), vld0, 1);
            chk($sformatf("rnd%0d.u", n), u0, eu);
            chk($sformatf("rnd%0d.un", n), un0, eun);
            chk($sformatf("rnd%0d.cnt", n), cnt0, cnt_exp(ek));
            chk($sformatf("rnd%0d.dis_u", n), u1, du);
            chk($sformatf("rnd%0d.dis_un", n), un1, dun);
            chk($sformatf("rnd%0d.dis_cnt", n), cnt1, cnt_exp(dk));
            stall($sformatf("rnd%0d", n), $urandom_range(0, 2), eu, ek);
            consume($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
